// File: rtl/alu_src_pipe.sv
// ----------------------------------------------------------------------------
// alu_src_pipe
//
// Registered ALU operand source selector. It accepts a request naming one of
// NSRC operand sources and waits until that source reports valid data. The
// operand is then held in a one-entry output register with valid/ready
// handshakes on both the request side and the ALU side. A select code of NSRC
// or above completes with an error (data 0) and does not return zero silently.
//
// Optional feature (macro ALU_SRC_TIMEOUT_EN):
//   When the macro is defined, a WAIT-cycle counter bounds the wait. After
//   TIMEOUT invalid WAIT cycles the request completes with an error. When the
//   macro is undefined, no counter is built and WAIT lasts until the source is
//   valid.
//
// Parameters:
//   WIDTH   - operand width in bits
//   NSRC    - number of sources (default map: 0 RF, 1 ID, 2 spare, 3 DM)
//   SEL_W   - select code width, $clog2(NSRC), minimum 1
//   TIMEOUT - maximum number of WAIT cycles before an error completion (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   src_data_i   packed source data, source i at [i*WIDTH +: WIDTH]
//   src_valid_i  per-source data valid
//   req_valid_i  operand request present
//   req_src_i    requested source index
//   req_ready_o  request can be accepted this cycle (combinational)
//   alu_data_o   registered operand
//   alu_tag_o    source index of the operand in alu_data_o
//   alu_err_o    error completion; alu_data_o is then 0
//   alu_valid_o  alu_data_o / alu_tag_o / alu_err_o are valid
//   alu_ready_i  ALU consumes the operand
// ----------------------------------------------------------------------------
module alu_src_pipe #(
    parameter int WIDTH   = 8,
    parameter int NSRC    = 4,
    parameter int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NSRC*WIDTH-1:0] src_data_i,
    input  logic [NSRC-1:0]       src_valid_i,
    input  logic                  req_valid_i,
    input  logic [SEL_W-1:0]      req_src_i,
    output logic                  req_ready_o,
    output logic [WIDTH-1:0]      alu_data_o,
    output logic [SEL_W-1:0]      alu_tag_o,
    output logic                  alu_err_o,
    output logic                  alu_valid_o,
    input  logic                  alu_ready_i
);

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("alu_src_pipe: TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [SEL_W-1:0] tag_q,   tag_d;
    logic             err_q,   err_d;
    logic             valid_q, valid_d;

`ifdef ALU_SRC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Source lookups. A code with no matching source (>= NSRC) reads as
    // not-legal / not-valid / zero, so no out-of-range slice is ever taken.
    function automatic logic sel_legal(input logic [SEL_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (idx == SEL_W'(i)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic sel_valid(input logic [SEL_W-1:0] idx,
                                       input logic [NSRC-1:0]  vld);
        logic v;
        v = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (idx == SEL_W'(i)) v = vld[i];
        end
        return v;
    endfunction

    function automatic logic [WIDTH-1:0] sel_data(input logic [SEL_W-1:0]      idx,
                                                  input logic [NSRC*WIDTH-1:0] dat);
        logic [WIDTH-1:0] d;
        d = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (idx == SEL_W'(i)) d = dat[i*WIDTH +: WIDTH];
        end
        return d;
    endfunction

    logic             accept;
    logic             req_legal;
    logic             req_hit;
    logic [WIDTH-1:0] req_word;
    logic             tag_hit;
    logic [WIDTH-1:0] tag_word;

    // The only input-to-output path: ready follows ALU_READY while in OUT.
    assign req_ready_o = (state_q == ST_IDLE) || ((state_q == ST_OUT) && alu_ready_i);
    assign accept      = req_valid_i && req_ready_o;

    assign req_legal = sel_legal(req_src_i);
    assign req_hit   = sel_valid(req_src_i, src_valid_i);
    assign req_word  = sel_data(req_src_i, src_data_i);
    assign tag_hit   = sel_valid(tag_q, src_valid_i);
    assign tag_word  = sel_data(tag_q, src_data_i);

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path
        // through the case statement leaves one unassigned (no latches).
        state_d = state_q;
        data_d  = data_q;
        tag_d   = tag_q;
        err_d   = err_q;
`ifdef ALU_SRC_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_OUT: begin
                if (accept) begin
                    // Accept from OUT behaves exactly like accept from IDLE,
                    // which is what gives one operand per cycle.
                    tag_d = req_src_i;
                    if (!req_legal) begin
                        state_d = ST_OUT;
                        data_d  = '0;
                        err_d   = 1'b1;
                    end else if (req_hit) begin
                        state_d = ST_OUT;
                        data_d  = req_word;
                        err_d   = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        data_d  = '0;
                        err_d   = 1'b0;
`ifdef ALU_SRC_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end else if ((state_q == ST_OUT) && alu_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tag_hit) begin
                    // Valid wins over a timeout expiring in the same cycle.
                    state_d = ST_OUT;
                    data_d  = tag_word;
                    err_d   = 1'b0;
                end
`ifdef ALU_SRC_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th invalid WAIT cycle.
                    state_d = ST_OUT;
                    data_d  = '0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the operand register is reset along with the control
            // state, so ALU_DATA/ALU_TAG read 0 after any reset.
            state_q <= ST_IDLE;
            data_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef ALU_SRC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every register samples
            // the pre-edge values regardless of statement order.
            state_q <= state_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
            valid_q <= valid_d;
`ifdef ALU_SRC_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign alu_data_o  = data_q;
    assign alu_tag_o   = tag_q;
    assign alu_err_o   = err_q;
    assign alu_valid_o = valid_q;

endmodule

// File: tb/tb_alu_src_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_src_pipe
//
// Bench for alu_src_pipe. The main instance uses NSRC=4 and a scoreboard: the
// expected operand is queued when a request is issued, and it is popped and
// compared when the ALU side consumes an operand. A second instance with
// NSRC=3 covers the illegal select code. Scenario tasks also compare the
// handshake and latency behaviour inline.
// ----------------------------------------------------------------------------
module tb_alu_src_pipe;

    localparam int WIDTH   = 8;
    localparam int NSRC    = 4;
    localparam int SEL_W   = 2;
    localparam int TIMEOUT = 15;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;

    logic [NSRC*WIDTH-1:0] src_data  = '0;
    logic [NSRC-1:0]       src_valid = '0;
    logic                  req_valid = 1'b0;
    logic [SEL_W-1:0]      req_src   = '0;
    logic                  req_ready;
    logic [WIDTH-1:0]      alu_data;
    logic [SEL_W-1:0]      alu_tag;
    logic                  alu_err;
    logic                  alu_valid;
    logic                  alu_ready = 1'b1;

    logic [3*WIDTH-1:0]    src_data2  = '0;
    logic [2:0]            src_valid2 = '0;
    logic                  req_valid2 = 1'b0;
    logic [1:0]            req_src2   = '0;
    logic                  req_ready2;
    logic [WIDTH-1:0]      alu_data2;
    logic [1:0]            alu_tag2;
    logic                  alu_err2;
    logic                  alu_valid2;
    logic                  alu_ready2 = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] tag;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    alu_src_pipe #(.WIDTH(WIDTH), .NSRC(NSRC), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data_i (src_data),
        .src_valid_i(src_valid),
        .req_valid_i(req_valid),
        .req_src_i  (req_src),
        .req_ready_o(req_ready),
        .alu_data_o (alu_data),
        .alu_tag_o  (alu_tag),
        .alu_err_o  (alu_err),
        .alu_valid_o(alu_valid),
        .alu_ready_i(alu_ready)
    );

    alu_src_pipe #(.WIDTH(WIDTH), .NSRC(3), .TIMEOUT(TIMEOUT)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_data_i (src_data2),
        .src_valid_i(src_valid2),
        .req_valid_i(req_valid2),
        .req_src_i  (req_src2),
        .req_ready_o(req_ready2),
        .alu_data_o (alu_data2),
        .alu_tag_o  (alu_tag2),
        .alu_err_o  (alu_err2),
        .alu_valid_o(alu_valid2),
        .alu_ready_i(alu_ready2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "time limit reached");
    end

    // {ready, valid, err, tag, data} of the main instance.
    function automatic logic [12:0] obs_main();
        return {req_ready, alu_valid, alu_err, alu_tag, alu_data};
    endfunction

    function automatic logic [11:0] obs_dut3();
        return {alu_valid2, alu_err2, alu_tag2, alu_data2};
    endfunction

    // Scoreboard: an operand transfers on the next rising edge whenever
    // valid and ready are both high in the middle of the cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && alu_valid && alu_ready) begin
            total_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got data=%h tag=%0d err=%b, required no operand",
                         alu_data, alu_tag, alu_err);
            end else begin
                e = sb_q.pop_front();
                if ({alu_data, alu_tag, alu_err} !== e)
                    $display("FAIL sb_operand: got data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                             alu_data, alu_tag, alu_err, e.data, e.tag, e.err);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request to the main instance and returns just after the
    // accept edge, with req_valid dropped again.
    task automatic issue(input logic [SEL_W-1:0] src, input int budget);
        bit ok;
        ok        = 1'b0;
        req_valid = 1'b1;
        req_src   = src;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (!ok) begin
            total_cnt++;
            $display("FAIL issue_accept: request src=%0d not accepted within %0d cycles", src, budget);
        end
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_state: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_release: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        src_valid     = 4'b0011;
        src_data[7:0] = 8'hA5;
        alu_ready     = 1'b1;
        sb_q.push_back('{data: 8'hA5, tag: 2'd0, err: 1'b0});
        issue(2'd0, 10);
        total_cnt++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 2'd0, 8'hA5})
            $display("FAIL basic_latency: got %h required %h", obs_main(), {1'b1, 1'b1, 1'b0, 2'd0, 8'hA5});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({req_ready, alu_valid} !== 2'b10)
            $display("FAIL basic_idle: got ready/valid %b required %b", {req_ready, alu_valid}, 2'b10);
        else pass_cnt++;
    endtask

    task automatic test_wait();
        bit early;
        early           = 1'b0;
        src_valid       = 4'b0011;
        src_data[31:24] = 8'h3C;
        sb_q.push_back('{data: 8'h3C, tag: 2'd3, err: 1'b0});
        issue(2'd3, 10);
        total_cnt++;
        if ({alu_valid, req_ready, alu_tag} !== 4'b0011)
            $display("FAIL wait_enter: got valid/ready/tag %b required %b", {alu_valid, req_ready, alu_tag}, 4'b0011);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (alu_valid !== 1'b0) early = 1'b1;
            tick();
        end
        total_cnt++;
        if (early)
            $display("FAIL wait_hold: got valid while source invalid, required valid=0");
        else pass_cnt++;
        src_valid[3] = 1'b1;
        tick();
        total_cnt++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 2'd3, 8'h3C})
            $display("FAIL wait_capture: got %h required %h", obs_main(), {1'b1, 1'b1, 1'b0, 2'd3, 8'h3C});
        else pass_cnt++;
        src_valid[3] = 1'b0;
        tick();
    endtask

`ifdef ALU_SRC_TIMEOUT_EN
    task automatic test_timeout();
        bit early;
        early           = 1'b0;
        src_valid       = 4'b0011;
        src_data[31:24] = 8'hDD;
        sb_q.push_back('{data: 8'h00, tag: 2'd3, err: 1'b1});
        issue(2'd3, 10);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if (alu_valid !== 1'b0) early = 1'b1;
        end
        total_cnt++;
        if (early)
            $display("FAIL timeout_early: got valid before %0d WAIT cycles, required valid=0", TIMEOUT);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (obs_main() !== {1'b1, 1'b1, 1'b1, 2'd3, 8'h00})
            $display("FAIL timeout_error: got %h required %h", obs_main(), {1'b1, 1'b1, 1'b1, 2'd3, 8'h00});
        else pass_cnt++;
        tick();
    endtask
`else
    task automatic test_wait_unbounded();
        bit early;
        early           = 1'b0;
        src_valid       = 4'b0011;
        src_data[31:24] = 8'h5B;
        issue(2'd3, 10);
        for (int i = 0; i < 40; i++) begin
            if (alu_valid !== 1'b0) early = 1'b1;
            tick();
        end
        total_cnt++;
        if (early)
            $display("FAIL wait_unbounded: got valid with source never valid, required valid=0");
        else pass_cnt++;
        sb_q.push_back('{data: 8'h5B, tag: 2'd3, err: 1'b0});
        src_valid[3] = 1'b1;
        tick();
        total_cnt++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 2'd3, 8'h5B})
            $display("FAIL wait_unbounded_capture: got %h required %h", obs_main(), {1'b1, 1'b1, 1'b0, 2'd3, 8'h5B});
        else pass_cnt++;
        src_valid[3] = 1'b0;
        tick();
    endtask
`endif

    // Source becomes valid during the TIMEOUT-th WAIT cycle: data must win.
    task automatic test_timeout_edge();
        bit early;
        early           = 1'b0;
        src_valid       = 4'b0011;
        src_data[31:24] = 8'hC3;
        sb_q.push_back('{data: 8'hC3, tag: 2'd3, err: 1'b0});
        issue(2'd3, 10);
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            if (alu_valid !== 1'b0) early = 1'b1;
        end
        src_valid[3] = 1'b1;
        tick();
        total_cnt++;
        if (early || obs_main() !== {1'b1, 1'b1, 1'b0, 2'd3, 8'hC3})
            $display("FAIL timeout_edge: got %h early=%b required %h early=0",
                     obs_main(), early, {1'b1, 1'b1, 1'b0, 2'd3, 8'hC3});
        else pass_cnt++;
        src_valid[3] = 1'b0;
        tick();
    endtask

    task automatic test_illegal();
        src_data2  = 24'h33_22_11;
        src_valid2 = 3'b111;
        alu_ready2 = 1'b1;
        req_src2   = 2'd3;
        req_valid2 = 1'b1;
        tick();
        req_valid2 = 1'b0;
        total_cnt++;
        if (obs_dut3() !== {1'b1, 1'b1, 2'd3, 8'h00})
            $display("FAIL illegal_code: got %h required %h", obs_dut3(), {1'b1, 1'b1, 2'd3, 8'h00});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({req_ready2, alu_valid2} !== 2'b10)
            $display("FAIL illegal_idle: got ready/valid %b required %b", {req_ready2, alu_valid2}, 2'b10);
        else pass_cnt++;
        req_src2   = 2'd2;
        req_valid2 = 1'b1;
        tick();
        req_valid2 = 1'b0;
        total_cnt++;
        if (obs_dut3() !== {1'b1, 1'b0, 2'd2, 8'h33})
            $display("FAIL legal_top_code: got %h required %h", obs_dut3(), {1'b1, 1'b0, 2'd2, 8'h33});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_hold_b2b();
        bit bad;
        bad            = 1'b0;
        src_valid      = 4'b0011;
        src_data[7:0]  = 8'h5A;
        src_data[15:8] = 8'h11;
        alu_ready      = 1'b0;
        sb_q.push_back('{data: 8'h5A, tag: 2'd0, err: 1'b0});
        issue(2'd0, 10);
        // Source data changes after capture and a request waits behind it.
        src_data[7:0] = 8'hEE;
        req_valid     = 1'b1;
        req_src       = 2'd1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (obs_main() !== {1'b0, 1'b1, 1'b0, 2'd0, 8'h5A}) bad = 1'b1;
            tick();
        end
        total_cnt++;
        if (bad)
            $display("FAIL hold_stall: got %h during stall, required %h", obs_main(), {1'b0, 1'b1, 1'b0, 2'd0, 8'h5A});
        else pass_cnt++;
        alu_ready = 1'b1;
        sb_q.push_back('{data: 8'h11, tag: 2'd1, err: 1'b0});
        #1;
        total_cnt++;
        if (req_ready !== 1'b1)
            $display("FAIL hold_ready_path: got req_ready=%b required 1", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++;
        if (obs_main() !== {1'b1, 1'b1, 1'b0, 2'd1, 8'h11})
            $display("FAIL hold_b2b: got %h required %h", obs_main(), {1'b1, 1'b1, 1'b0, 2'd1, 8'h11});
        else pass_cnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        bit          bad;
        logic [31:0] rnd;
        logic [1:0]  s;
        bad       = 1'b0;
        src_valid = 4'b1111;
        alu_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rnd       = $urandom;
            s         = 2'(i);
            src_data  = rnd;
            req_src   = s;
            req_valid = 1'b1;
            sb_q.push_back('{data: rnd[s*8 +: 8], tag: s, err: 1'b0});
            #1;
            if (req_ready !== 1'b1) bad = 1'b1;
            tick();
            if (alu_valid !== 1'b1 || alu_tag !== s) bad = 1'b1;
        end
        req_valid = 1'b0;
        total_cnt++;
        if (bad)
            $display("FAIL b2b_throughput: got a bubble or wrong tag, required one operand per cycle");
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({req_ready, alu_valid} !== 2'b10)
            $display("FAIL b2b_drain: got ready/valid %b required %b", {req_ready, alu_valid}, 2'b10);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        // Reset while in WAIT: the latched tag must clear at once.
        src_valid = 4'b0011;
        alu_ready = 1'b1;
        issue(2'd3, 10);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_in_wait: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_wait_release: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;

        // Reset while in OUT with the operand stalled.
        alu_ready      = 1'b0;
        src_data[15:8] = 8'h77;
        issue(2'd1, 10);
        total_cnt++;
        if (obs_main() !== {1'b0, 1'b1, 1'b0, 2'd1, 8'h77})
            $display("FAIL reset_out_setup: got %h required %h", obs_main(), {1'b0, 1'b1, 1'b0, 2'd1, 8'h77});
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_in_out: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        tick();
        total_cnt++;
        if (obs_main() !== 13'h1000)
            $display("FAIL reset_out_release: got %h required %h", obs_main(), 13'h1000);
        else pass_cnt++;
        alu_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait();
`ifdef ALU_SRC_TIMEOUT_EN
        test_timeout();
`else
        test_wait_unbounded();
`endif
        test_timeout_edge();
        test_illegal();
        test_hold_b2b();
        test_back_to_back();
        test_reset_mid();
        tick();
        tick();
        total_cnt++;
        if (sb_q.size() != 0)
            $display("FAIL sb_leftover: got %0d operands never delivered, required 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
